palette_engine: RTL and testbench

- Programmable multi-palette colour lookup for the video pipeline, the successor of the fixed three-colour palette.
- Holds NUM_PAL palettes of NUM_COL RGB entries in registers, preloaded at reset with the team's default colour sets.
- Entries are rewritable at runtime through a write port.
- A pixel index is translated to a colour through a fixed 2-cycle pipeline.
- Optionally, a palette switch cross-fades from the old palette to the new one.

---
 rtl/palette_pkg.sv | 26 ++
 rtl/palette_blend.sv | 33 +++
 rtl/palette_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_palette_engine.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup engine.
// Optional cross-fade is enabled with the PALETTE_FADE_EN macro (see palette_engine).
package palette_pkg;

  // Default colours are authored as 4-bit channels and scaled to the build width.
  localparam int DEF_CH_W = 4;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  // Entries 0..2 of palettes 0..2; entry 3 and up default to black.
  localparam rgb_t [0:2][0:2] DEFAULT_PAL = '{
    '{rgb_t'(12'hF00), rgb_t'(12'h0F0), rgb_t'(12'h00F)},
    '{rgb_t'(12'hFF0), rgb_t'(12'h0FF), rgb_t'(12'hF0F)},
    '{rgb_t'(12'hFAA), rgb_t'(12'hAAF), rgb_t'(12'hAFA)}
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fade_state_t;

endpackage

// File: rtl/palette_blend.sv
// Single-channel linear interpolator: old + ((new-old)*step >>> SHIFT).
// Purely combinational; the engine instantiates one per colour channel.
module palette_blend #(
  parameter int CH_W   = 4,
  parameter int STEP_W = 5,
  parameter int SHIFT  = 4
) (
  input  logic [CH_W-1:0]   old_c,
  input  logic [CH_W-1:0]   new_c,
  input  logic [STEP_W-1:0] step,
  output logic [CH_W-1:0]   mix_c
);

  // Product holds a signed CH_W+1 difference times an unsigned STEP_W step.
  localparam int PW = CH_W + STEP_W + 2;

  logic signed [CH_W:0] diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] step_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // Signed difference, scaled by step, arithmetic shift, truncated add back onto old.
  always_comb begin
    diff    = $signed({1'b0, new_c}) - $signed({1'b0, old_c});
    diff_x  = {{(PW-CH_W-1){diff[CH_W]}}, diff};
    step_x  = {{(PW-STEP_W){1'b0}}, step};
    prod    = diff_x * step_x;
    shifted = prod >>> SHIFT;
    mix_c   = old_c + shifted[CH_W-1:0];
  end

endmodule

// File: rtl/palette_engine.sv
// Multi-palette colour lookup with runtime-writable entries and a fixed
// 2-cycle pixel pipeline. Define PALETTE_FADE_EN to cross-fade between
// palettes on a switch; otherwise a switch takes effect on the next edge.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// may be raised at any time, ready never depends combinationally on valid.
module palette_engine
  import palette_pkg::*;
#(
  parameter int NUM_PAL     = 4,
  parameter int NUM_COL     = 4,
  parameter int CH_W        = 4,
  parameter int FADE_STEPS  = 16,
  parameter int STEP_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [$clog2(NUM_COL)-1:0] wr_idx,
  input  logic [3*CH_W-1:0]          wr_color,
  input  logic                       sel_valid,
  output logic                       sel_ready,
  input  logic [$clog2(NUM_PAL)-1:0] sel_pal,
  output logic [$clog2(NUM_PAL)-1:0] active_pal,
  output logic                       busy,
  input  logic                       px_valid,
  input  logic [$clog2(NUM_COL)-1:0] px_idx,
  output logic                       out_valid,
  output logic [3*CH_W-1:0]          out_color
);

  localparam int PAL_W = $clog2(NUM_PAL);
  localparam int COL_W = 3 * CH_W;

  // Reset colour for palette p, entry i, with 4-bit defaults replicated to CH_W bits.
  function automatic logic [COL_W-1:0] default_color(input int p, input int i);
    rgb_t        c;
    logic [1:0]  ps;
    logic [1:0]  is;
    logic [31:0] rep_r;
    logic [31:0] rep_g;
    logic [31:0] rep_b;
    c  = '0;
    ps = (p < 3) ? p[1:0] : 2'd0;
    is = i[1:0];
    if (i < 3) c = DEFAULT_PAL[ps][is];
    rep_r = {8{c.r}};
    rep_g = {8{c.g}};
    rep_b = {8{c.b}};
    return {rep_r[31 -: CH_W], rep_g[31 -: CH_W], rep_b[31 -: CH_W]};
  endfunction

  logic [COL_W-1:0] pal_mem [NUM_PAL][NUM_COL];
  logic             ready_q;
  logic [PAL_W-1:0] active_q;
  logic             s1_valid;

  // Ready rises on the first edge after reset release and then stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign wr_ready   = ready_q;
  assign active_pal = active_q;

  // Palette storage: defaults on reset, accepted writes update one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < NUM_COL; i++)
          pal_mem[p][i] <= default_color(p, i);
    end else if (wr_valid && ready_q) begin
      pal_mem[wr_pal][wr_idx] <= wr_color;
    end
  end

`ifdef PALETTE_FADE_EN

  localparam int SHIFT  = $clog2(FADE_STEPS);
  localparam int STEP_W = SHIFT + 1;
  localparam int PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  fade_state_t       state_q;
  fade_state_t       state_d;
  logic [PAL_W-1:0]  tgt_q;
  logic [PRE_W-1:0]  pre_q;
  logic [STEP_W-1:0] step_q;
  logic              sel_fire;
  logic              start_fade;
  logic              pre_wrap;
  logic              fade_done;
  logic [COL_W-1:0]  s1_old;
  logic [COL_W-1:0]  s1_new;
  logic [STEP_W-1:0] s1_step;
  logic [COL_W-1:0]  mix_color;

  assign sel_fire   = sel_valid && sel_ready;
  assign start_fade = sel_fire && (sel_pal != active_q);
  assign pre_wrap   = (pre_q == PRE_W'(STEP_CYCLES - 1));
  assign fade_done  = pre_wrap && (step_q == STEP_W'(FADE_STEPS - 1));

  // Fade FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Fade FSM next state: start on a real palette change, end when step reaches FADE_STEPS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_fade) state_d = ST_FADE;
      ST_FADE: if (fade_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fade FSM outputs.
  always_comb begin
    busy      = (state_q == ST_FADE);
    sel_ready = ready_q && (state_q == ST_IDLE);
  end

  // Target latch, prescaler and step counter; the palette swap lands on the final wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      tgt_q    <= '0;
      pre_q    <= '0;
      step_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_fade) begin
        tgt_q  <= sel_pal;
        pre_q  <= '0;
        step_q <= '0;
      end
    end else if (pre_wrap) begin
      pre_q <= '0;
      if (fade_done) begin
        active_q <= tgt_q;
        step_q   <= '0;
      end else begin
        step_q <= step_q + 1'b1;
      end
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Stage 1: fetch old and new entries plus the blend weight in effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_old   <= '0;
      s1_new   <= '0;
      s1_step  <= '0;
    end else begin
      s1_valid <= px_valid;
      if (px_valid) begin
        s1_old  <= pal_mem[active_q][px_idx];
        s1_new  <= pal_mem[tgt_q][px_idx];
        s1_step <= busy ? step_q : '0;
      end
    end
  end

  palette_blend #(.CH_W(CH_W), .STEP_W(STEP_W), .SHIFT(SHIFT)) u_blend_r (
    .old_c(s1_old[3*CH_W-1 -: CH_W]), .new_c(s1_new[3*CH_W-1 -: CH_W]),
    .step(s1_step), .mix_c(mix_color[3*CH_W-1 -: CH_W])
  );
  palette_blend #(.CH_W(CH_W), .STEP_W(STEP_W), .SHIFT(SHIFT)) u_blend_g (
    .old_c(s1_old[2*CH_W-1 -: CH_W]), .new_c(s1_new[2*CH_W-1 -: CH_W]),
    .step(s1_step), .mix_c(mix_color[2*CH_W-1 -: CH_W])
  );
  palette_blend #(.CH_W(CH_W), .STEP_W(STEP_W), .SHIFT(SHIFT)) u_blend_b (
    .old_c(s1_old[CH_W-1 -: CH_W]), .new_c(s1_new[CH_W-1 -: CH_W]),
    .step(s1_step), .mix_c(mix_color[CH_W-1 -: CH_W])
  );

`else

  logic [COL_W-1:0] s1_color;
  logic [COL_W-1:0] mix_color;
  logic             unused_cfg;

  // Fade timing parameters have no meaning when switches are immediate.
  assign unused_cfg = ^{FADE_STEPS[0], STEP_CYCLES[0]};
  assign busy       = 1'b0;
  assign sel_ready  = ready_q;
  assign mix_color  = s1_color;

  // An accepted switch takes effect on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     active_q <= '0;
    else if (sel_valid && sel_ready) active_q <= sel_pal;
  end

  // Stage 1: fetch the displayed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_color <= '0;
    end else begin
      s1_valid <= px_valid;
      if (px_valid) s1_color <= pal_mem[active_q][px_idx];
    end
  end

`endif

  // Stage 2: register the final colour; hold it while no pixel is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out_color <= mix_color;
    end
  end

endmodule

// File: tb/tb_palette_engine.sv
// Directed bench for palette_engine; covers the fade build when PALETTE_FADE_EN is defined.
module tb_palette_engine;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_pal;
  logic [1:0]  wr_idx;
  logic [11:0] wr_color;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  sel_pal;
  logic [1:0]  active_pal;
  logic        busy;
  logic        px_valid;
  logic [1:0]  px_idx;
  logic        out_valid;
  logic [11:0] out_color;

  int pass_cnt  = 0;
  int total_cnt = 0;

  palette_engine #(
    .NUM_PAL(4), .NUM_COL(4), .CH_W(4), .FADE_STEPS(16), .STEP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal), .wr_idx(wr_idx),
    .wr_color(wr_color),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_pal(sel_pal),
    .active_pal(active_pal), .busy(busy),
    .px_valid(px_valid), .px_idx(px_idx),
    .out_valid(out_valid), .out_color(out_color)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver: single lookup; returns out_valid one cycle after issue and the result two cycles after.
  task automatic do_lookup(input logic [1:0] idx, output logic early_v,
                           output logic v, output logic [11:0] c);
    @(negedge clk);
    px_valid = 1'b1;
    px_idx   = idx;
    @(negedge clk);
    px_valid = 1'b0;
    early_v  = out_valid;
    @(negedge clk);
    v = out_valid;
    c = out_color;
  endtask

  // Driver: single palette write.
  task automatic do_write(input logic [1:0] p, input logic [1:0] i, input logic [11:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_pal   = p;
    wr_idx   = i;
    wr_color = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Driver: single select pulse.
  task automatic do_select(input logic [1:0] p);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_pal   = p;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    wr_valid  = 1'b0; wr_pal = '0; wr_idx = '0; wr_color = '0;
    sel_valid = 1'b0; sel_pal = '0;
    px_valid  = 1'b0; px_idx = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({wr_ready, sel_ready, busy, out_valid} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {wr_ready, sel_ready, busy, out_valid});
    else pass_cnt++;
    total_cnt++;
    if (active_pal !== 2'd0) $display("FAIL reset_active got %0d want 0", active_pal);
    else pass_cnt++;
    total_cnt++;
    if (out_color !== 12'h000) $display("FAIL reset_color got %h want 000", out_color);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({wr_ready, sel_ready, busy} !== 3'b110) $display("FAIL ready_after_reset got %b want 110", {wr_ready, sel_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_lookup;
    logic [11:0] want [4];
    logic        ev, v;
    logic [11:0] c;
    want[0] = 12'hF00; want[1] = 12'h0F0; want[2] = 12'h00F; want[3] = 12'h000;
    for (int i = 0; i < 4; i++) begin
      do_lookup(2'(i), ev, v, c);
      total_cnt++;
      if (ev !== 1'b0 || v !== 1'b1) $display("FAIL lookup_latency idx%0d got early=%b valid=%b want 0/1", i, ev, v);
      else pass_cnt++;
      total_cnt++;
      if (c !== want[i]) $display("FAIL lookup_pal0 idx%0d got %h want %h", i, c, want[i]);
      else pass_cnt++;
    end
    // Idle output holds last colour.
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || out_color !== 12'h000) $display("FAIL lookup_hold got v=%b c=%h want 0/000", out_valid, out_color);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] want [3];
    want[0] = 12'hF00; want[1] = 12'h0F0; want[2] = 12'h00F;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_color !== want[k-2]) $display("FAIL b2b_slot%0d got v=%b c=%h want 1/%h", k-2, out_valid, out_color, want[k-2]);
        else pass_cnt++;
      end
      px_valid = (k < 3);
      px_idx   = 2'(k);
    end
    px_valid = 1'b0;
  endtask

  task automatic test_write_rbw;
    logic        ev, v;
    logic [11:0] c;
    @(negedge clk);
    wr_valid = 1'b1; wr_pal = 2'd0; wr_idx = 2'd1; wr_color = 12'h123;
    px_valid = 1'b1; px_idx = 2'd1;
    @(negedge clk);
    wr_valid = 1'b0; px_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_color !== 12'h0F0) $display("FAIL write_rbw got v=%b c=%h want 1/0f0", out_valid, out_color);
    else pass_cnt++;
    do_lookup(2'd1, ev, v, c);
    total_cnt++;
    if (v !== 1'b1 || c !== 12'h123) $display("FAIL write_new got v=%b c=%h want 1/123", v, c);
    else pass_cnt++;
    do_lookup(2'd2, ev, v, c);
    total_cnt++;
    if (c !== 12'h00F) $display("FAIL write_neighbour got %h want 00f", c);
    else pass_cnt++;
  endtask

`ifdef PALETTE_FADE_EN

  task automatic test_fade;
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    sel_valid = 1'b1; sel_pal = 2'd1;
    px_valid  = 1'b1; px_idx  = 2'd0;
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      if (k == 0) sel_valid = 1'b0;
      if (busy) busy_cycles++;
      if (k == 2) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_color !== 12'hF00) $display("FAIL fade_step0 got v=%b c=%h want 1/f00", out_valid, out_color);
        else pass_cnt++;
      end
      if (k == 10) begin
        total_cnt++;
        if (sel_ready !== 1'b0) $display("FAIL fade_sel_blocked got %b want 0", sel_ready);
        else pass_cnt++;
        sel_valid = 1'b1; sel_pal = 2'd2;
      end
      if (k == 11) sel_valid = 1'b0;
      if (k == 34) begin
        total_cnt++;
        if (out_color !== 12'hF70) $display("FAIL fade_step8 got %h want f70", out_color);
        else pass_cnt++;
      end
      if (k == 63) begin
        total_cnt++;
        if (busy !== 1'b1 || active_pal !== 2'd0) $display("FAIL fade_last_busy got busy=%b act=%0d want 1/0", busy, active_pal);
        else pass_cnt++;
      end
      if (k == 64) begin
        total_cnt++;
        if (busy !== 1'b0 || active_pal !== 2'd1 || sel_ready !== 1'b1) $display("FAIL fade_end got busy=%b act=%0d rdy=%b want 0/1/1", busy, active_pal, sel_ready);
        else pass_cnt++;
      end
      if (k == 65) begin
        total_cnt++;
        if (out_color !== 12'hFE0) $display("FAIL fade_step15 got %h want fe0", out_color);
        else pass_cnt++;
      end
      if (k == 66) begin
        total_cnt++;
        if (out_color !== 12'hFF0) $display("FAIL fade_step16 got %h want ff0", out_color);
        else pass_cnt++;
      end
    end
    px_valid = 1'b0;
    total_cnt++;
    if (busy_cycles !== 64) $display("FAIL fade_busy_len got %0d want 64", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_sel_same;
    do_select(2'd1);
    total_cnt++;
    if (busy !== 1'b0 || active_pal !== 2'd1) $display("FAIL sel_same got busy=%b act=%0d want 0/1", busy, active_pal);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || sel_ready !== 1'b1) $display("FAIL sel_same_idle got busy=%b rdy=%b want 0/1", busy, sel_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_midfade;
    logic        ev, v;
    logic [11:0] c;
    do_write(2'd0, 2'd0, 12'h123);
    @(negedge clk);
    sel_valid = 1'b1; sel_pal = 2'd0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) sel_valid = 1'b0;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midfade_busy got %b want 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || active_pal !== 2'd0 || sel_ready !== 1'b0 || wr_ready !== 1'b0) $display("FAIL midfade_reset got busy=%b act=%0d srdy=%b wrdy=%b want 0/0/0/0", busy, active_pal, sel_ready, wr_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(2'd0, ev, v, c);
    total_cnt++;
    if (v !== 1'b1 || c !== 12'hF00) $display("FAIL midfade_revert idx0 got v=%b c=%h want 1/f00", v, c);
    else pass_cnt++;
    do_lookup(2'd1, ev, v, c);
    total_cnt++;
    if (c !== 12'h0F0) $display("FAIL midfade_revert idx1 got %h want 0f0", c);
    else pass_cnt++;
  endtask

`else

  task automatic test_select_nofade;
    logic [11:0] want [4];
    logic        ev, v;
    logic [11:0] c;
    want[0] = 12'hFAA; want[1] = 12'hAAF; want[2] = 12'hAFA; want[3] = 12'h000;
    do_select(2'd2);
    total_cnt++;
    if (active_pal !== 2'd2 || busy !== 1'b0 || sel_ready !== 1'b1) $display("FAIL sel_immediate got act=%0d busy=%b rdy=%b want 2/0/1", active_pal, busy, sel_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      do_lookup(2'(i), ev, v, c);
      total_cnt++;
      if (v !== 1'b1 || c !== want[i] || busy !== 1'b0) $display("FAIL lookup_pal2 idx%0d got v=%b c=%h busy=%b want 1/%h/0", i, v, c, busy, want[i]);
      else pass_cnt++;
    end
    do_select(2'd1);
    do_lookup(2'd2, ev, v, c);
    total_cnt++;
    if (active_pal !== 2'd1 || c !== 12'hF0F) $display("FAIL lookup_pal1 idx2 got act=%0d c=%h want 1/f0f", active_pal, c);
    else pass_cnt++;
    // Palette 3 is an independent copy of the palette 0 defaults.
    do_select(2'd3);
    do_lookup(2'd1, ev, v, c);
    total_cnt++;
    if (active_pal !== 2'd3 || c !== 12'h0F0) $display("FAIL lookup_pal3 idx1 got act=%0d c=%h want 3/0f0", active_pal, c);
    else pass_cnt++;
  endtask

  task automatic test_reset_restore;
    logic        ev, v;
    logic [11:0] c;
    do_write(2'd3, 2'd0, 12'h5A5);
    do_lookup(2'd0, ev, v, c);
    total_cnt++;
    if (c !== 12'h5A5) $display("FAIL restore_prewrite got %h want 5a5", c);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (active_pal !== 2'd0 || out_color !== 12'h000) $display("FAIL restore_reset got act=%0d c=%h want 0/000", active_pal, out_color);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_select(2'd3);
    do_lookup(2'd0, ev, v, c);
    total_cnt++;
    if (c !== 12'hF00) $display("FAIL restore_default got %h want f00", c);
    else pass_cnt++;
    do_select(2'd0);
    do_lookup(2'd1, ev, v, c);
    total_cnt++;
    if (c !== 12'h0F0) $display("FAIL restore_pal0 got %h want 0f0", c);
    else pass_cnt++;
  endtask

`endif

  initial begin
    test_reset();
    test_lookup();
    test_back_to_back();
    test_write_rbw();
`ifdef PALETTE_FADE_EN
    test_fade();
    test_sel_same();
    test_reset_midfade();
`else
    test_select_nofade();
    test_reset_restore();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
